// File: rtl/uart_msg_assembler.sv
// Assembles UART bytes into 16-bit display words with error/timeout handling.
// Optional UART_MSG_CHECKSUM_EN adds a third XOR checksum byte per message.
module uart_msg_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] ERR_PATTERN    = 16'hEEEE,
  parameter logic [15:0] RESET_PATTERN  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ferror,
  input  logic        rx_perror,
  output logic [15:0] signal_to_display,
  output logic        msg_valid,
  output logic        msg_error,
  output logic [7:0]  err_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_LO = 2'd1;
`ifdef UART_MSG_CHECKSUM_EN
  localparam logic [1:0] S_WAIT_CK = 2'd2;
`endif

  logic [1:0]    state;
  logic [1:0]    nxt_state;
  logic [7:0]    hi;
  logic [CW-1:0] cnt;
  logic          byte_ok;
  logic          byte_err;
  logic          timed_out;
  logic          ld_hi;
  logic          clr_cnt;
  logic          inc_cnt;
  logic          commit;
  logic          err;
  logic [15:0]   commit_word;

  assign byte_err  = rx_valid & (rx_ferror | rx_perror);
  assign byte_ok   = rx_valid & ~(rx_ferror | rx_perror);
  assign timed_out = (cnt == CNT_LAST);

`ifdef UART_MSG_CHECKSUM_EN
  logic [7:0] lo;
  logic       ld_lo;
  assign commit_word = {hi, lo};
`else
  assign commit_word = {hi, rx_data};
`endif

  always_comb begin
    nxt_state = state;
    ld_hi     = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
`ifdef UART_MSG_CHECKSUM_EN
    ld_lo     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (byte_ok) begin
          ld_hi     = 1'b1;
          clr_cnt   = 1'b1;
          nxt_state = S_WAIT_LO;
        end else if (byte_err) begin
          err = 1'b1;
        end
      end
      S_WAIT_LO: begin
        nxt_state = S_IDLE;
        if (byte_ok) begin
`ifdef UART_MSG_CHECKSUM_EN
          ld_lo     = 1'b1;
          clr_cnt   = 1'b1;
          nxt_state = S_WAIT_CK;
`else
          commit = 1'b1;
`endif
        end else if (byte_err || timed_out) begin
          err = 1'b1;
        end else begin
          inc_cnt   = 1'b1;
          nxt_state = S_WAIT_LO;
        end
      end
`ifdef UART_MSG_CHECKSUM_EN
      S_WAIT_CK: begin
        nxt_state = S_IDLE;
        if (byte_ok) begin
          if (rx_data == (hi ^ lo)) commit = 1'b1;
          else                      err    = 1'b1;
        end else if (byte_err || timed_out) begin
          err = 1'b1;
        end else begin
          inc_cnt   = 1'b1;
          nxt_state = S_WAIT_CK;
        end
      end
`endif
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      hi                <= 8'h00;
      cnt               <= '0;
      signal_to_display <= RESET_PATTERN;
      msg_valid         <= 1'b0;
      msg_error         <= 1'b0;
      err_cnt           <= 8'h00;
    end else begin
      state     <= nxt_state;
      msg_valid <= commit;
      msg_error <= err;
      if (ld_hi)        hi  <= rx_data;
      if (clr_cnt)      cnt <= '0;
      else if (inc_cnt) cnt <= cnt + 1'b1;
      if (commit) signal_to_display <= commit_word;
      if (err) begin
        signal_to_display <= ERR_PATTERN;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef UART_MSG_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)      lo <= 8'h00;
    else if (ld_lo) lo <= rx_data;
  end
`endif

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Directed bench for uart_msg_assembler (two-byte or checksum build).
// Define UART_MSG_CHECKSUM_EN to exercise the three-byte variant.
module tb_uart_msg_assembler;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ferror = 1'b0;
  logic        rx_perror = 1'b0;
  logic [15:0] signal_to_display;
  logic        msg_valid;
  logic        msg_error;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  uart_msg_assembler #(
    .TIMEOUT_CYCLES(TO),
    .ERR_PATTERN(16'hEEEE),
    .RESET_PATTERN(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ferror(rx_ferror),
    .rx_perror(rx_perror),
    .signal_to_display(signal_to_display),
    .msg_valid(msg_valid),
    .msg_error(msg_error),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Presents one byte for exactly one edge; returns 1ns after that edge.
  task automatic strobe(input logic [7:0] d, input logic fe, input logic pe);
    @(negedge clk);
    rx_data   = d;
    rx_valid  = 1'b1;
    rx_ferror = fe;
    rx_perror = pe;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends the tail byte(s) after hi; in checksum builds lo then hi^lo.
  task automatic finish_msg(input logic [7:0] h, input logic [7:0] l);
    strobe(l, 1'b0, 1'b0);
`ifdef UART_MSG_CHECKSUM_EN
    strobe(h ^ l, 1'b0, 1'b0);
`else
    if (h == 8'h00) ; // hi is only consumed by the checksum build
`endif
  endtask

  task automatic test_reset();
    do_reset();
    idle(10);
    checks++;
    if (signal_to_display !== 16'h0000) begin
      errors++;
      $display("FAIL reset_disp got=%h exp=0000", signal_to_display);
    end
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mv got=%b exp=0", msg_valid);
    end
    checks++;
    if (msg_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_me got=%b exp=0", msg_error);
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_cnt got=%h exp=00", err_cnt);
    end
  endtask

  task automatic test_basic();
    strobe(8'h12, 1'b0, 1'b0);
    idle(4);
    finish_msg(8'h12, 8'h34);
    checks++;
    if (signal_to_display !== 16'h1234 || msg_valid !== 1'b1 ||
        msg_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_msg got=%h mv=%b me=%b exp=1234 1 0",
               signal_to_display, msg_valid, msg_error);
    end
    idle(1);
    checks++;
    if (msg_valid !== 1'b0 || signal_to_display !== 16'h1234) begin
      errors++;
      $display("FAIL basic_hold got=%h mv=%b exp=1234 0",
               signal_to_display, msg_valid);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    strobe(8'hAB, 1'b0, 1'b0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      idle(1);
      k++;
      if (msg_error === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k != TO) begin
      errors++;
      $display("FAIL timeout_cycles got=%0d seen=%b exp=%0d", k, seen, TO);
    end
    checks++;
    if (signal_to_display !== 16'hEEEE || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout_err got=%h cnt=%0d exp=eeee 1",
               signal_to_display, err_cnt);
    end
    strobe(8'h56, 1'b0, 1'b0);
    finish_msg(8'h56, 8'h78);
    checks++;
    if (signal_to_display !== 16'h5678 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_timeout got=%h mv=%b exp=5678 1",
               signal_to_display, msg_valid);
    end
    // Byte on the final allowed edge must beat the timeout.
    strobe(8'h11, 1'b0, 1'b0);
    idle(TO - 1);
    finish_msg(8'h11, 8'h22);
    checks++;
    if (signal_to_display !== 16'h1122 || msg_valid !== 1'b1 ||
        msg_error !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL edge_wins got=%h mv=%b me=%b cnt=%0d exp=1122 1 0 1",
               signal_to_display, msg_valid, msg_error, err_cnt);
    end
  endtask

  task automatic test_errors();
    strobe(8'h01, 1'b0, 1'b0);
    strobe(8'h02, 1'b0, 1'b1);
    checks++;
    if (signal_to_display !== 16'hEEEE || msg_error !== 1'b1 ||
        msg_valid !== 1'b0 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL perror got=%h me=%b mv=%b cnt=%0d exp=eeee 1 0 2",
               signal_to_display, msg_error, msg_valid, err_cnt);
    end
    // Flags without rx_valid must be ignored.
    @(negedge clk);
    rx_ferror = 1'b1;
    rx_perror = 1'b1;
    idle(3);
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
    checks++;
    if (err_cnt !== 8'd2 || msg_error !== 1'b0) begin
      errors++;
      $display("FAIL flags_no_valid cnt=%0d me=%b exp=2 0", err_cnt, msg_error);
    end
    for (int i = 0; i < 260; i++) strobe(8'(i), i[0], ~i[0]);
    checks++;
    if (err_cnt !== 8'hFF || msg_error !== 1'b1) begin
      errors++;
      $display("FAIL saturate cnt=%h me=%b exp=ff 1", err_cnt, msg_error);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    strobe(8'h9A, 1'b0, 1'b0);
    finish_msg(8'h9A, 8'hBC);
    checks++;
    if (signal_to_display !== 16'h9ABC || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got=%h mv=%b exp=9abc 1",
               signal_to_display, msg_valid);
    end
    strobe(8'hDE, 1'b0, 1'b0);
    checks++;
    if (msg_valid !== 1'b0 || signal_to_display !== 16'h9ABC) begin
      errors++;
      $display("FAIL b2b_mid got=%h mv=%b exp=9abc 0",
               signal_to_display, msg_valid);
    end
    finish_msg(8'hDE, 8'hF0);
    checks++;
    if (signal_to_display !== 16'hDEF0 || msg_valid !== 1'b1 ||
        err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_second got=%h mv=%b cnt=%0d exp=def0 1 0",
               signal_to_display, msg_valid, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    strobe(8'h12, 1'b0, 1'b0);
    do_reset();
    pulses = 0;
    strobe(8'h34, 1'b0, 1'b0);
    if (msg_valid === 1'b1 || msg_error === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (msg_valid === 1'b1 || msg_error === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || signal_to_display !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid pulses=%0d got=%h exp=0 0000",
               pulses, signal_to_display);
    end
    do_reset();
  endtask

`ifdef UART_MSG_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    strobe(8'h12, 1'b0, 1'b0);
    strobe(8'h34, 1'b0, 1'b0);
    checks++;
    if (msg_valid !== 1'b0 || signal_to_display !== 16'h0000) begin
      errors++;
      $display("FAIL ck_no_early got=%h mv=%b exp=0000 0",
               signal_to_display, msg_valid);
    end
    strobe(8'h26, 1'b0, 1'b0);
    checks++;
    if (signal_to_display !== 16'h1234 || msg_valid !== 1'b1) begin
      errors++;
      $display("FAIL ck_good got=%h mv=%b exp=1234 1",
               signal_to_display, msg_valid);
    end
    strobe(8'h12, 1'b0, 1'b0);
    strobe(8'h34, 1'b0, 1'b0);
    strobe(8'h27, 1'b0, 1'b0);
    checks++;
    if (signal_to_display !== 16'hEEEE || msg_error !== 1'b1 ||
        msg_valid !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ck_bad got=%h me=%b mv=%b cnt=%0d exp=eeee 1 0 1",
               signal_to_display, msg_error, msg_valid, err_cnt);
    end
  endtask
`endif

  // Both pulses high together is never legal.
  always @(negedge clk) begin
    if (!reset && msg_valid === 1'b1 && msg_error === 1'b1) begin
      errors++;
      $display("FAIL pulse_overlap mv=%b me=%b exp=not both",
               msg_valid, msg_error);
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_MSG_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
